// File: rtl/demux4_pkg.sv
// Shared constants and types for the four-channel word distributor.
package demux4_pkg;
    localparam int CH_NUM      = 4;
    localparam int BIT_DEFAULT = 4;

    typedef logic [1:0] chan_t;
endpackage

// File: rtl/demux4_dist_if.sv
// Producer/consumer bus of demux4_dist: one input stream fanned out to four held channels.
interface demux4_dist_if
    import demux4_pkg::*;
#(
    parameter int BIT = BIT_DEFAULT
);
    logic [BIT-1:0]    in_data;
    logic              in_valid;
    logic              in_ready;
    chan_t             sel;
    logic              rr_mode;
    logic [BIT-1:0]    out0;
    logic [BIT-1:0]    out1;
    logic [BIT-1:0]    out2;
    logic [BIT-1:0]    out3;
    logic [CH_NUM-1:0] out_valid;
    logic [CH_NUM-1:0] out_ready;
    chan_t             ch_last;
    logic [7:0]        xfer_cnt;

    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out0, out1, out2, out3, out_valid, ch_last, xfer_cnt
    );

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out0, out1, out2, out3, out_valid, ch_last, xfer_cnt
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register: load wins over drain, drain only clears valid.
module demux_slot #(
    parameter int BIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_drain,
    input  logic [BIT-1:0] i_data,
    output logic [BIT-1:0] o_data,
    output logic           o_valid
);
    logic [BIT-1:0] r_data;
    logic           r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/demux4_dist.sv
// Distributes an input word stream to four held channels, targeted by sel or round-robin.
module demux4_dist
    import demux4_pkg::*;
#(
    parameter int BIT = BIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    demux4_dist_if.slave  bus
);
    chan_t             r_rr_ptr;
    chan_t             r_ch_last;
    logic [7:0]        r_xfer_cnt;
    chan_t             w_tgt;
    logic              w_in_ready;
    logic              w_accept;
    logic [BIT-1:0]    w_data [CH_NUM];
    logic [CH_NUM-1:0] w_valid;

    assign w_tgt = bus.rr_mode ? r_rr_ptr : bus.sel;
    // A channel being drained this cycle can take the next word without a bubble.
    assign w_in_ready = !reset && (!w_valid[w_tgt] || bus.out_ready[w_tgt]);
    assign w_accept   = bus.in_valid && w_in_ready;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
        demux_slot #(.BIT(BIT)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_accept && (w_tgt == chan_t'(k))),
            .i_drain (bus.out_ready[k]),
            .i_data  (bus.in_data),
            .o_data  (w_data[k]),
            .o_valid (w_valid[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_ch_last  <= '0;
            r_xfer_cnt <= '0;
        end else if (w_accept) begin
            if (bus.rr_mode) begin
                r_rr_ptr <= r_rr_ptr + chan_t'(1);
            end
            r_ch_last  <= w_tgt;
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out0      = w_data[0];
    assign bus.out1      = w_data[1];
    assign bus.out2      = w_data[2];
    assign bus.out3      = w_data[3];
    assign bus.out_valid = w_valid;
    assign bus.ch_last   = r_ch_last;
    assign bus.xfer_cnt  = r_xfer_cnt;
endmodule

// File: tb/tb_demux4_dist.sv
// Self-checking bench for demux4_dist: directed scenarios plus random traffic against a channel model.
module tb_demux4_dist;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    demux4_dist_if #(.BIT(4)) bus ();

    demux4_dist #(.BIT(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each channel holds, plus pointer/last/count bookkeeping.
    logic [3:0] m_data [4];
    logic [3:0] m_valid;
    int         m_ptr, m_last, m_cnt;
    logic       obs_rdy, exp_rdy;

    function automatic logic [29:0] exp_vec();
        return {m_data[3], m_data[2], m_data[1], m_data[0], m_valid, 2'(m_last), 8'(m_cnt)};
    endfunction

    function automatic logic [29:0] obs_vec();
        return {bus.out3, bus.out2, bus.out1, bus.out0, bus.out_valid, bus.ch_last, bus.xfer_cnt};
    endfunction

    // One clock: sample in_ready before the edge, advance the model, settle 1ns after the edge.
    task automatic tick();
        int  t;
        bit  acc;
        #1;
        t       = bus.rr_mode ? m_ptr : int'(bus.sel);
        obs_rdy = bus.in_ready;
        exp_rdy = !reset && (!m_valid[t] || bus.out_ready[t]);
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 4; k++) m_data[k] = '0;
            m_valid = '0;
            m_ptr = 0; m_last = 0; m_cnt = 0;
        end else begin
            acc = bus.in_valid && exp_rdy;
            m_valid = m_valid & ~bus.out_ready;
            if (acc) begin
                m_data[t]  = bus.in_data;
                m_valid[t] = 1'b1;
                m_last     = t;
                m_cnt      = (m_cnt + 1) % 256;
                if (bus.rr_mode) m_ptr = (m_ptr + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 4'h7; bus.sel = 2'd0;
        bus.rr_mode = 1'b0; bus.out_ready = '0;
        tick();
        checks++;
        if (obs_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=0", obs_rdy);
        end
        checks++;
        if (obs_vec() !== 30'd0) begin
            errors++; $display("FAIL reset_state got=%h exp=0", obs_vec());
        end
        reset = 1'b0; bus.in_valid = 1'b0;
        tick();
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got=%b exp=1", obs_rdy);
        end
    endtask

    task automatic test_sel_fill();
        logic [1:0] sels [4];
        logic [3:0] dats [4];
        sels = '{2'd3, 2'd2, 2'd1, 2'd0};
        dats = '{4'd1, 4'd0, 4'd3, 4'd5};
        bus.rr_mode = 1'b0; bus.out_ready = '0; bus.in_valid = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.sel = sels[i]; bus.in_data = dats[i];
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (obs_vec() !== {4'd1, 4'd0, 4'd3, 4'd5, 4'b1111, 2'd0, 8'd4}) begin
            errors++; $display("FAIL sel_fill got=%h exp=%h", obs_vec(),
                               {4'd1, 4'd0, 4'd3, 4'd5, 4'b1111, 2'd0, 8'd4});
        end
    endtask

    task automatic test_full_stall();
        bus.in_valid = 1'b1; bus.sel = 2'd2; bus.in_data = 4'hA; bus.out_ready = '0;
        tick();
        checks++;
        if (obs_rdy !== 1'b0 || bus.out2 !== 4'd0) begin
            errors++; $display("FAIL stall got rdy=%b out2=%h exp rdy=0 out2=0", obs_rdy, bus.out2);
        end
        bus.out_ready = 4'b0100;
        tick();
        checks++;
        if (obs_rdy !== 1'b1 || bus.out2 !== 4'hA || bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL stall_release got rdy=%b out2=%h vld=%b exp rdy=1 out2=a vld=1111",
                               obs_rdy, bus.out2, bus.out_valid);
        end
        bus.in_valid = 1'b0; bus.out_ready = '0;
    endtask

    task automatic test_drain_load();
        bus.rr_mode = 1'b0; bus.sel = 2'd1; bus.in_data = 4'd9;
        bus.in_valid = 1'b1; bus.out_ready = 4'b0010;
        tick();
        checks++;
        if (obs_rdy !== 1'b1 || bus.out1 !== 4'd9 || bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL drain_load got rdy=%b out1=%h vld=%b exp rdy=1 out1=9 vld=1111",
                               obs_rdy, bus.out1, bus.out_valid);
        end
        bus.in_valid = 1'b0; bus.out_ready = '0;
    endtask

    task automatic test_rr_wrap();
        do_reset();
        bus.rr_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            bus.in_data = 4'(i + 1);
            tick();
            checks++;
            if (obs_rdy !== 1'b1 || bus.ch_last !== 2'(i % 4)) begin
                errors++; $display("FAIL rr_word%0d got rdy=%b ch=%0d exp rdy=1 ch=%0d",
                                   i, obs_rdy, bus.ch_last, i % 4);
            end
        end
        checks++;
        if (bus.out0 !== 4'd5 || bus.out1 !== 4'd6) begin
            errors++; $display("FAIL rr_final got out0=%h out1=%h exp out0=5 out1=6", bus.out0, bus.out1);
        end
        // Pointer must now sit on channel 2.
        bus.in_data = 4'd7;
        tick();
        checks++;
        if (bus.ch_last !== 2'd2 || bus.out2 !== 4'd7) begin
            errors++; $display("FAIL rr_ptr got ch=%0d out2=%h exp ch=2 out2=7", bus.ch_last, bus.out2);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        bus.rr_mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
        for (int unsigned i = 0; i < 256; i++) begin
            bus.in_data = 4'($urandom);
            tick();
            if (i == 254) begin
                checks++;
                if (bus.xfer_cnt !== 8'd255) begin
                    errors++; $display("FAIL cnt_255 got=%0d exp=255", bus.xfer_cnt);
                end
            end
        end
        checks++;
        if (bus.xfer_cnt !== 8'd0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL cnt_wrap got=%h exp=%h", obs_vec(), exp_vec());
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rr_mode = 1'b0; bus.out_ready = '0; bus.in_valid = 1'b1;
        bus.sel = 2'd1; bus.in_data = 4'd3; tick();
        bus.sel = 2'd2; bus.in_data = 4'd4; tick();
        checks++;
        if (bus.out_valid !== 4'b0110) begin
            errors++; $display("FAIL mid_setup got=%b exp=0110", bus.out_valid);
        end
        bus.sel = 2'd0; bus.in_data = 4'd7; bus.out_ready = 4'b0010; reset = 1'b1;
        tick();
        checks++;
        if (obs_rdy !== 1'b0 || obs_vec() !== 30'd0) begin
            errors++; $display("FAIL mid_reset got rdy=%b st=%h exp rdy=0 st=0", obs_rdy, obs_vec());
        end
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = '0;
        tick();
        checks++;
        if (obs_rdy !== 1'b1 || obs_vec() !== 30'd0) begin
            errors++; $display("FAIL mid_after got rdy=%b st=%h exp rdy=1 st=0", obs_rdy, obs_vec());
        end
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.in_data   = 4'($urandom);
            bus.sel       = 2'($urandom);
            bus.rr_mode   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            bus.out_ready = 4'($urandom) & 4'($urandom);
            tick();
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_rdy%0d got=%b exp=%b", i, obs_rdy, exp_rdy);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rand_state%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        reset = 1'b0; bus.in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) m_data[k] = '0;
        m_valid = '0; m_ptr = 0; m_last = 0; m_cnt = 0;
        test_reset();
        test_sel_fill();
        test_full_stall();
        test_drain_load();
        test_rr_wrap();
        test_cnt_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
